if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline.
- Owns the fetch PC, issues single-outstanding requests to instruction memory, and loads the IF/ID pipeline register.
- Consumes the EX-stage redirect: `redirect_valid` = jump | branch_taken, `redirect_pc` = resolved next_pc.
- Squashes wrong-path instructions held in IF/ID and in flight in memory, and signals the ID/EX flush.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- NOP_INSTR, 32'h0000_0013, instruction presented in IF/ID when it holds a bubble (addi x0,x0,0).

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- redirect_valid  input  1  EX resolved a taken branch/jump this cycle
- redirect_pc  input  32  target PC from EX
- stall  input  1  hazard unit: hold IF/ID contents
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  32  fetch address, word aligned
- imem_rsp_valid  input  1  response data valid (one per accepted request, in order)
- imem_rsp_data  input  32  fetched instruction
- if_id_valid  output  1  IF/ID holds a live instruction
- if_id_pc  output  32  PC of IF/ID instruction
- if_id_pc_plus4  output  32  if_id_pc + 4
- if_id_instr  output  32  instruction word
- flush_id_ex  output  1  squash the instruction entering ID/EX

Behaviour:
- Reset:
  - state = ISSUE, fetch_pc = RESET_PC, req_pc = 0, skid empty.
  - if_id_valid = 0, if_id_pc = 0, if_id_pc_plus4 = 0, if_id_instr = NOP_INSTR.
  - imem_req_valid = 0 while rst is high.
  - rst overrides every other input, including mid-request. A response arriving after reset for a pre-reset request is dropped (state enters DISCARD if a request was outstanding).
- Address alignment: redirect_pc[1:0] is forced to 2'b00. imem_req_addr = {fetch_pc[31:2], 2'b00}. The +4 arithmetic is modulo 2^32 (0xFFFF_FFFC wraps to 0).
- States: ISSUE, WAIT, DISCARD.
  - ISSUE:
    - imem_req_valid = !skid_valid && !redirect_valid.
    - On valid & ready: req_pc <= fetch_pc, fetch_pc <= fetch_pc + 4, go to WAIT.
  - WAIT, on imem_rsp_valid with no redirect:
    - Load IF/ID with {1, req_pc, req_pc+4, rsp_data} if IF/ID is loadable; otherwise write the skid buffer.
    - Return to ISSUE. A new request may not issue in the same cycle as the response (max 1 outstanding, 1 instr per 2 cycles minimum).
  - DISCARD: a stale request is outstanding. On imem_rsp_valid, drop the data and go to ISSUE. imem_req_valid = 0.
- IF/ID loadable = !(stall && if_id_valid).
  - When loadable and skid_valid: load from skid, clear skid.
  - When loadable with no source: if_id_valid <= 0, instr <= NOP_INSTR (bubble).
  - When stalled: all IF/ID outputs hold.
- Skid: one entry {pc, instr}. Filled only when a response arrives while IF/ID is held. While full, no request issues.
- Redirect has top priority over stall and response in the same cycle:
  - flush_id_ex = redirect_valid (combinational, same cycle).
  - fetch_pc <= aligned redirect_pc, if_id_valid <= 0, if_id_instr <= NOP_INSTR, skid cleared. IF/ID is cleared even if stall = 1.
  - From WAIT without rsp_valid: go to DISCARD. From WAIT with rsp_valid: the response is dropped, go to ISSUE.
  - From ISSUE: no request issues, stay in ISSUE.
  - From DISCARD: fetch_pc updates, stay DISCARD unless rsp_valid that cycle, in which case go to ISSUE.
- Back-to-back redirects: the last one wins, and no wrong-path instruction ever reaches if_id_valid = 1.
- imem_rsp_valid in ISSUE is a protocol error and is ignored.

Test Plan:
- Reset release, imem ready=1, 1-cycle response latency:
  - Expect requests to 0x0, 0x4, 0x8 on alternate cycles.
  - Expect if_id_pc 0x0/0x4/0x8 with matching instr and pc_plus4.
  - Expect if_id_instr = 0x13 and if_id_valid = 0 on bubble cycles.
- Hold stall=1 with if_id_valid=1 while a response for 0x8 arrives:
  - Skid captures it, IF/ID holds 0x4, no new request issues.
  - Drop stall: IF/ID loads 0x8 next edge, then requests resume at 0xC.
- Pulse redirect_valid, redirect_pc=0x100 while in WAIT with no response:
  - flush_id_ex=1 that cycle, if_id_valid=0.
  - The late response for the old PC is dropped.
  - Next request address is 0x100.
- Redirect coincident with imem_rsp_valid and stall=1:
  - Response dropped, IF/ID cleared despite stall, skid empty.
  - Next fetch at the target.
- Two redirects on consecutive cycles (0x200 then 0x300) during DISCARD: only 0x300 is fetched. redirect_pc=0x302 yields imem_req_addr 0x300.
- Assert rst while a request is outstanding with imem_req_ready low, then release:
  - Outputs at reset values, first request to RESET_PC.
  - A stale response is dropped.
  - Also run fetch_pc=0xFFFF_FFFC: next request address wraps to 0x0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, keeps one request in flight to instruction
// memory, fills the IF/ID register (with a one-entry skid) and squashes wrong-path fetches.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instr,
    output logic        flush_id_ex
);

    typedef enum logic [1:0] {
        StIssue,
        StWait,
        StDiscard
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;

    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;

    logic        if_id_valid_q, if_id_valid_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;

    logic        req_fire;
    logic        rsp_accept;
    logic        loadable;
    logic [31:0] redirect_pc_aligned;

    assign redirect_pc_aligned = {redirect_pc[31:2], 2'b00};

    assign imem_req_valid = (state_q == StIssue) && !skid_valid_q && !redirect_valid && !rst;
    assign imem_req_addr  = {fetch_pc_q[31:2], 2'b00};
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response is only useful in WAIT and only if no redirect squashes it this cycle.
    assign rsp_accept = (state_q == StWait) && imem_rsp_valid && !redirect_valid;
    assign loadable   = !(stall && if_id_valid_q);

    assign flush_id_ex    = redirect_valid;
    assign if_id_valid    = if_id_valid_q;
    assign if_id_pc       = if_id_pc_q;
    assign if_id_pc_plus4 = if_id_pc_plus4_q;
    assign if_id_instr    = if_id_instr_q;

    // Fetch control FSM
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;

        unique case (state_q)
            StIssue: begin
                if (req_fire) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (imem_rsp_valid) begin
                    state_d = StIssue;
                end else if (redirect_valid) begin
                    state_d = StDiscard;
                end
            end
            StDiscard: begin
                if (imem_rsp_valid) begin
                    state_d = StIssue;
                end
            end
            default: state_d = StIssue;
        endcase

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc_aligned;
        end
    end

    // IF/ID register and skid buffer
    always_comb begin
        skid_valid_d     = skid_valid_q;
        skid_pc_d        = skid_pc_q;
        skid_instr_d     = skid_instr_q;
        if_id_valid_d    = if_id_valid_q;
        if_id_pc_d       = if_id_pc_q;
        if_id_pc_plus4_d = if_id_pc_plus4_q;
        if_id_instr_d    = if_id_instr_q;

        if (redirect_valid) begin
            // Redirect clears IF/ID even under stall; pc fields keep their old values.
            skid_valid_d  = 1'b0;
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
        end else if (loadable) begin
            if (skid_valid_q) begin
                skid_valid_d     = 1'b0;
                if_id_valid_d    = 1'b1;
                if_id_pc_d       = skid_pc_q;
                if_id_pc_plus4_d = skid_pc_q + 32'd4;
                if_id_instr_d    = skid_instr_q;
            end else if (rsp_accept) begin
                if_id_valid_d    = 1'b1;
                if_id_pc_d       = req_pc_q;
                if_id_pc_plus4_d = req_pc_q + 32'd4;
                if_id_instr_d    = imem_rsp_data;
            end else begin
                if_id_valid_d = 1'b0;
                if_id_instr_d = NOP_INSTR;
            end
        end else if (rsp_accept) begin
            skid_valid_d = 1'b1;
            skid_pc_d    = req_pc_q;
            skid_instr_d = imem_rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // A request still in flight across reset must have its response swallowed.
            if ((state_q == StWait || state_q == StDiscard) && !imem_rsp_valid) begin
                state_q <= StDiscard;
            end else begin
                state_q <= StIssue;
            end
            fetch_pc_q       <= RESET_PC;
            req_pc_q         <= 32'd0;
            skid_valid_q     <= 1'b0;
            skid_pc_q        <= 32'd0;
            skid_instr_q     <= 32'd0;
            if_id_valid_q    <= 1'b0;
            if_id_pc_q       <= 32'd0;
            if_id_pc_plus4_q <= 32'd0;
            if_id_instr_q    <= NOP_INSTR;
        end else begin
            state_q          <= state_d;
            fetch_pc_q       <= fetch_pc_d;
            req_pc_q         <= req_pc_d;
            skid_valid_q     <= skid_valid_d;
            skid_pc_q        <= skid_pc_d;
            skid_instr_q     <= skid_instr_d;
            if_id_valid_q    <= if_id_valid_d;
            if_id_pc_q       <= if_id_pc_d;
            if_id_pc_plus4_q <= if_id_pc_plus4_d;
            if_id_instr_q    <= if_id_instr_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: sequential fetch, skid under stall, redirects,
// reset with a request outstanding and PC wrap-around.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic        flush_id_ex;

    int n_checks;
    int n_fail;

    if_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .stall         (stall),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .if_id_valid   (if_id_valid),
        .if_id_pc      (if_id_pc),
        .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_instr   (if_id_instr),
        .flush_id_ex   (flush_id_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    // Inputs change on the falling edge; outputs are read 1ns later.
    task automatic drive(input logic r, input logic rv, input logic [31:0] rpc,
                         input logic st, input logic rdy, input logic rspv,
                         input logic [31:0] rspd);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        stall          = st;
        imem_req_ready = rdy;
        imem_rsp_valid = rspv;
        imem_rsp_data  = rspd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 1, 0, 0);
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_req_valid: got %0b want 0", imem_req_valid);
        end
        tick();
        tick();
        drive(1, 0, 0, 0, 1, 0, 0);
        n_checks++;
        if (if_id_valid !== 1'b0 || if_id_pc !== 32'd0 || if_id_pc_plus4 !== 32'd0) begin
            n_fail++; $display("FAIL reset_if_id: got v=%0b pc=%h p4=%h want 0/0/0",
                               if_id_valid, if_id_pc, if_id_pc_plus4);
        end
        n_checks++;
        if (if_id_instr !== 32'h13 || imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_instr: got instr=%h rv=%0b want 13/0",
                               if_id_instr, imem_req_valid);
        end
    endtask

    task automatic test_seq_fetch();
        drive(0, 0, 0, 0, 1, 0, 0);
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            n_fail++; $display("FAIL seq_req0: got v=%0b a=%h want 1/0", imem_req_valid,
                               imem_req_addr);
        end
        tick();
        drive(0, 0, 0, 0, 1, 1, mk(32'h0));
        n_checks++;
        if (imem_req_valid !== 1'b0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h13) begin
            n_fail++; $display("FAIL seq_bubble0: got rv=%0b v=%0b i=%h want 0/0/13",
                               imem_req_valid, if_id_valid, if_id_instr);
        end
        tick();
        drive(0, 0, 0, 0, 1, 0, 0);
        n_checks++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || if_id_pc_plus4 !== 32'h4 ||
            if_id_instr !== mk(32'h0)) begin
            n_fail++; $display("FAIL seq_ifid0: got v=%0b pc=%h p4=%h i=%h want 1/0/4/%h",
                               if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr, mk(32'h0));
        end
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin
            n_fail++; $display("FAIL seq_req4: got v=%0b a=%h want 1/4", imem_req_valid,
                               imem_req_addr);
        end
        tick();
        drive(0, 0, 0, 0, 1, 1, mk(32'h4));
        n_checks++;
        if (if_id_valid !== 1'b0 || if_id_instr !== 32'h13) begin
            n_fail++; $display("FAIL seq_bubble1: got v=%0b i=%h want 0/13", if_id_valid,
                               if_id_instr);
        end
        tick();
        drive(0, 0, 0, 0, 1, 0, 0);
        n_checks++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h4 || if_id_pc_plus4 !== 32'h8 ||
            if_id_instr !== mk(32'h4)) begin
            n_fail++; $display("FAIL seq_ifid4: got v=%0b pc=%h p4=%h i=%h want 1/4/8/%h",
                               if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr, mk(32'h4));
        end
    endtask

    task automatic test_stall_skid();
        drive(0, 0, 0, 1, 1, 0, 0);
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin
            n_fail++; $display("FAIL skid_req8: got v=%0b a=%h want 1/8", imem_req_valid,
                               imem_req_addr);
        end
        tick();
        drive(0, 0, 0, 1, 1, 1, mk(32'h8));
        n_checks++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h4) begin
            n_fail++; $display("FAIL skid_hold0: got v=%0b pc=%h want 1/4", if_id_valid,
                               if_id_pc);
        end
        tick();
        drive(0, 0, 0, 1, 1, 0, 0);
        n_checks++;
        if (imem_req_valid !== 1'b0 || if_id_pc !== 32'h4 || if_id_instr !== mk(32'h4)) begin
            n_fail++; $display("FAIL skid_full: got rv=%0b pc=%h i=%h want 0/4/%h",
                               imem_req_valid, if_id_pc, if_id_instr, mk(32'h4));
        end
        tick();
        drive(0, 0, 0, 0, 1, 0, 0);
        n_checks++;
        if (imem_req_valid !== 1'b0 || if_id_pc !== 32'h4) begin
            n_fail++; $display("FAIL skid_release: got rv=%0b pc=%h want 0/4", imem_req_valid,
                               if_id_pc);
        end
        tick();
        drive(0, 0, 0, 0, 1, 0, 0);
        n_checks++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h8 || if_id_pc_plus4 !== 32'hC ||
            if_id_instr !== mk(32'h8)) begin
            n_fail++; $display("FAIL skid_load: got v=%0b pc=%h p4=%h i=%h want 1/8/c/%h",
                               if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr, mk(32'h8));
        end
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hC) begin
            n_fail++; $display("FAIL skid_resume: got v=%0b a=%h want 1/c", imem_req_valid,
                               imem_req_addr);
        end
        tick();
    endtask

    task automatic test_redirect_wait();
        drive(0, 1, 32'h100, 0, 1, 0, 0);
        n_checks++;
        if (flush_id_ex !== 1'b1 || imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL rdw_flush: got f=%0b rv=%0b want 1/0", flush_id_ex,
                               imem_req_valid);
        end
        tick();
        drive(0, 0, 0, 0, 1, 1, mk(32'hC));
        n_checks++;
        if (flush_id_ex !== 1'b0 || if_id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL rdw_discard: got f=%0b v=%0b rv=%0b want 0/0/0",
                               flush_id_ex, if_id_valid, imem_req_valid);
        end
        tick();
        drive(0, 0, 0, 0, 1, 0, 0);
        n_checks++;
        if (if_id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
            n_fail++; $display("FAIL rdw_target: got v=%0b rv=%0b a=%h want 0/1/100",
                               if_id_valid, imem_req_valid, imem_req_addr);
        end
        tick();
        drive(0, 0, 0, 0, 1, 1, mk(32'h100));
        tick();
        drive(0, 0, 0, 1, 1, 0, 0);
        n_checks++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h100 || imem_req_addr !== 32'h104) begin
            n_fail++; $display("FAIL rdw_fetch100: got v=%0b pc=%h a=%h want 1/100/104",
                               if_id_valid, if_id_pc, imem_req_addr);
        end
        tick();
    endtask

    task automatic test_redirect_rsp_stall();
        drive(0, 1, 32'h180, 1, 1, 1, mk(32'h104));
        n_checks++;
        if (flush_id_ex !== 1'b1 || if_id_pc !== 32'h100 || if_id_valid !== 1'b1) begin
            n_fail++; $display("FAIL rrs_pre: got f=%0b v=%0b pc=%h want 1/1/100",
                               flush_id_ex, if_id_valid, if_id_pc);
        end
        tick();
        drive(0, 0, 0, 1, 0, 0, 0);
        n_checks++;
        if (if_id_valid !== 1'b0 || if_id_instr !== 32'h13) begin
            n_fail++; $display("FAIL rrs_cleared: got v=%0b i=%h want 0/13", if_id_valid,
                               if_id_instr);
        end
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h180) begin
            n_fail++; $display("FAIL rrs_target: got v=%0b a=%h want 1/180", imem_req_valid,
                               imem_req_addr);
        end
        drive(0, 0, 0, 0, 1, 0, 0);
        tick();
    endtask

    task automatic test_back_to_back();
        drive(0, 1, 32'h200, 0, 1, 0, 0);
        n_checks++;
        if (flush_id_ex !== 1'b1) begin
            n_fail++; $display("FAIL b2b_flush0: got %0b want 1", flush_id_ex);
        end
        tick();
        drive(0, 1, 32'h302, 0, 1, 0, 0);
        n_checks++;
        if (flush_id_ex !== 1'b1 || imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_flush1: got f=%0b rv=%0b want 1/0", flush_id_ex,
                               imem_req_valid);
        end
        tick();
        drive(0, 0, 0, 0, 1, 1, mk(32'h180));
        n_checks++;
        if (imem_req_valid !== 1'b0 || if_id_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_discard: got rv=%0b v=%0b want 0/0", imem_req_valid,
                               if_id_valid);
        end
        tick();
        drive(0, 0, 0, 0, 1, 0, 0);
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300 || if_id_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_target: got rv=%0b a=%h v=%0b want 1/300/0",
                               imem_req_valid, imem_req_addr, if_id_valid);
        end
        tick();
        drive(0, 0, 0, 0, 1, 1, mk(32'h300));
        tick();
        drive(0, 0, 0, 0, 1, 0, 0);
        n_checks++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h300 || if_id_pc_plus4 !== 32'h304 ||
            if_id_instr !== mk(32'h300)) begin
            n_fail++; $display("FAIL b2b_ifid: got v=%0b pc=%h p4=%h i=%h want 1/300/304/%h",
                               if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr,
                               mk(32'h300));
        end
        n_checks++;
        if (imem_req_addr !== 32'h304) begin
            n_fail++; $display("FAIL b2b_next: got a=%h want 304", imem_req_addr);
        end
        tick();
    endtask

    task automatic test_reset_midrequest();
        drive(1, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstm_req: got %0b want 0", imem_req_valid);
        end
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (if_id_valid !== 1'b0 || if_id_pc !== 32'd0 || if_id_pc_plus4 !== 32'd0 ||
            if_id_instr !== 32'h13) begin
            n_fail++; $display("FAIL rstm_ifid: got v=%0b pc=%h p4=%h i=%h want 0/0/0/13",
                               if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr);
        end
        tick();
        drive(0, 0, 0, 0, 0, 1, mk(32'h304));
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstm_discard: got rv=%0b want 0", imem_req_valid);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (if_id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            n_fail++; $display("FAIL rstm_first: got v=%0b rv=%0b a=%h want 0/1/0",
                               if_id_valid, imem_req_valid, imem_req_addr);
        end
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstm_lowrdy: got rv=%0b want 0", imem_req_valid);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            n_fail++; $display("FAIL rstm_issue: got rv=%0b a=%h want 1/0", imem_req_valid,
                               imem_req_addr);
        end
    endtask

    task automatic test_wrap();
        drive(0, 1, 32'hFFFF_FFFE, 0, 1, 0, 0);
        n_checks++;
        if (imem_req_valid !== 1'b0 || flush_id_ex !== 1'b1) begin
            n_fail++; $display("FAIL wrap_redirect: got rv=%0b f=%0b want 0/1",
                               imem_req_valid, flush_id_ex);
        end
        tick();
        drive(0, 0, 0, 0, 1, 0, 0);
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_addr: got rv=%0b a=%h want 1/fffffffc",
                               imem_req_valid, imem_req_addr);
        end
        tick();
        drive(0, 0, 0, 0, 1, 1, mk(32'hFFFF_FFFC));
        tick();
        drive(0, 0, 0, 0, 1, 0, 0);
        n_checks++;
        if (if_id_pc !== 32'hFFFF_FFFC || if_id_pc_plus4 !== 32'h0 ||
            if_id_instr !== mk(32'hFFFF_FFFC)) begin
            n_fail++; $display("FAIL wrap_ifid: got pc=%h p4=%h i=%h want fffffffc/0/%h",
                               if_id_pc, if_id_pc_plus4, if_id_instr, mk(32'hFFFF_FFFC));
        end
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            n_fail++; $display("FAIL wrap_next: got rv=%0b a=%h want 1/0", imem_req_valid,
                               imem_req_addr);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_seq_fetch();
        test_stall_skid();
        test_redirect_wait();
        test_redirect_rsp_stall();
        test_back_to_back();
        test_reset_midrequest();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
